// File: rtl/strobe_pkg.sv
// strobe_pkg: shared event/state types and the one-hot grant encoder for strobe_sequencer.
package strobe_pkg;

    typedef struct packed {
        logic       rel;
        logic [1:0] chan;
    } evt_t;

    typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

    typedef struct packed {
        logic       valid;
        logic       err;
        logic [1:0] chan;
    } enc_t;

    function automatic enc_t onehot_enc(input logic [3:0] v);
        return '{valid: $onehot(v), err: (v != 4'd0) && !$onehot(v), chan: {v[3] | v[2], v[3] | v[1]}};
    endfunction

endpackage

// File: rtl/strobe_fifo2w.sv
// strobe_fifo2w: dual-write single-read event FIFO; free space already accounts for a same-cycle pop.
module strobe_fifo2w
    import strobe_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we0,
    input  evt_t                     i_d0,
    input  logic                     i_we1,
    input  evt_t                     i_d1,
    input  logic                     i_re,
    output evt_t                     o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [$clog2(DEPTH):0]   o_level_nxt,
    output logic [$clog2(DEPTH):0]   o_free
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    evt_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;

    assign o_head      = r_mem[r_rptr];
    assign o_level     = r_level;
    assign o_free      = LW'(DEPTH) - r_level + LW'(i_re);
    assign o_level_nxt = r_level + LW'(i_we0) + LW'(i_we1) - LW'(i_re);

    // i_we1 is only ever raised together with i_we0, so d1 lands one slot after d0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (i_we0) r_mem[r_wptr] <= i_d0;
            if (i_we1) r_mem[r_wptr + AW'(1)] <= i_d1;
            r_wptr  <= r_wptr + AW'(i_we0) + AW'(i_we1);
            r_rptr  <= r_rptr + AW'(i_re);
            r_level <= o_level_nxt;
        end
    end

endmodule

// File: rtl/strobe_sequencer.sv
// strobe_sequencer: queues abs/rel grants and replays them as timed strobe pulses with saturating statistics.
module strobe_sequencer
    import strobe_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1,
    parameter int CNT_W     = 8
) (
    input  logic                     ref_clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [3:0]               abs_idx,
    input  logic [3:0]               rel_idx,
    input  logic                     busy,
    output logic                     strobe,
    output logic                     strb_rel,
    output logic [1:0]               strb_chan,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         busy_cnt,
    output logic [CNT_W-1:0]         ovf_cnt,
    output logic                     err,
    output logic                     idle
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(PULSE_CYC + GAP_CYC + 1) + 1;

    enc_t            w_abs;
    enc_t            w_rel;
    evt_t            w_e0;
    evt_t            w_e1;
    evt_t            w_head;
    logic [1:0]      w_n;
    logic [1:0]      w_acc;
    logic [1:0]      w_drop;
    logic [LW-1:0]   w_level;
    logic [LW-1:0]   w_level_nxt;
    logic [LW-1:0]   w_free;
    logic [CNT_W:0]  w_ovf_sum;
    logic            w_pop;
    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_strobe;
    evt_t            r_evt;
    logic [CNT_W-1:0] r_busy_cnt;
    logic [CNT_W-1:0] r_ovf_cnt;
    logic            r_err;
    logic            r_idle;

    assign w_abs     = onehot_enc(abs_idx);
    assign w_rel     = onehot_enc(rel_idx);
    assign w_n       = {1'b0, w_abs.valid} + {1'b0, w_rel.valid};
    assign w_e0      = w_abs.valid ? {1'b0, w_abs.chan} : {1'b1, w_rel.chan};
    assign w_e1      = {1'b1, w_rel.chan};
    // when space runs short the earlier (abs) event wins the remaining slot
    assign w_acc     = (w_free >= LW'(w_n)) ? w_n : w_free[1:0];
    assign w_drop    = w_n - w_acc;
    assign w_ovf_sum = {1'b0, r_ovf_cnt} + (CNT_W + 1)'(w_drop);

    strobe_fifo2w #(.DEPTH(DEPTH)) u_fifo (
        .i_clk       (ref_clk),
        .i_rst       (reset),
        .i_we0       (w_acc != 2'd0),
        .i_d0        (w_e0),
        .i_we1       (w_acc == 2'd2),
        .i_d1        (w_e1),
        .i_re        (w_pop),
        .o_head      (w_head),
        .o_level     (w_level),
        .o_level_nxt (w_level_nxt),
        .o_free      (w_free)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: if (en && w_level != '0) begin
                w_pop       = 1'b1;
                w_state_nxt = STROBE;
                w_cnt_nxt   = CW'(PULSE_CYC - 1);
            end
            STROBE: if (r_cnt == '0) begin
                w_state_nxt = (GAP_CYC > 0) ? GAP : IDLE;
                w_cnt_nxt   = CW'(GAP_CYC) - CW'(1);
            end else begin
                w_cnt_nxt   = r_cnt - CW'(1);
            end
            GAP: if (r_cnt == '0) w_state_nxt = IDLE;
                 else w_cnt_nxt = r_cnt - CW'(1);
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_strobe   <= 1'b0;
            r_evt      <= '0;
            r_busy_cnt <= '0;
            r_ovf_cnt  <= '0;
            r_err      <= 1'b0;
            r_idle     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_strobe   <= w_state_nxt == STROBE;
            if (w_pop) r_evt <= w_head;
            if (busy && !(&r_busy_cnt)) r_busy_cnt <= r_busy_cnt + CNT_W'(1);
            r_ovf_cnt  <= w_ovf_sum[CNT_W] ? '1 : w_ovf_sum[CNT_W-1:0];
            r_err      <= r_err | w_abs.err | w_rel.err;
            r_idle     <= (w_state_nxt == IDLE) && (w_level_nxt == '0);
        end
    end

    assign strobe    = r_strobe;
    assign strb_rel  = r_evt.rel;
    assign strb_chan = r_evt.chan;
    assign level     = w_level;
    assign busy_cnt  = r_busy_cnt;
    assign ovf_cnt   = r_ovf_cnt;
    assign err       = r_err;
    assign idle      = r_idle;

endmodule

// File: tb/tb_strobe_sequencer.sv
// tb_strobe_sequencer: table-driven and hand-sequenced directed checks of strobe_sequencer.
module tb_strobe_sequencer;

    logic       ref_clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] abs_idx;
    logic [3:0] rel_idx;
    logic       busy;
    logic       strobe;
    logic       strb_rel;
    logic [1:0] strb_chan;
    logic [3:0] level;
    logic [7:0] busy_cnt;
    logic [7:0] ovf_cnt;
    logic       err;
    logic       idle;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic [3:0] abs_v;
        logic [3:0] rel_v;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[14];

    strobe_sequencer dut (
        .ref_clk   (ref_clk),
        .reset     (reset),
        .en        (en),
        .abs_idx   (abs_idx),
        .rel_idx   (rel_idx),
        .busy      (busy),
        .strobe    (strobe),
        .strb_rel  (strb_rel),
        .strb_chan (strb_chan),
        .level     (level),
        .busy_cnt  (busy_cnt),
        .ovf_cnt   (ovf_cnt),
        .err       (err),
        .idle      (idle)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] a, input logic [3:0] r);
        en      = e;
        abs_idx = a;
        rel_idx = r;
    endtask

    initial begin
        logic [2:0] exp_ev[9];
        logic       prev;
        int         n;

        // {strobe, strb_rel, strb_chan, level, idle}
        tbl[0]  = '{1'b1, 4'b0100, 4'b0000, {1'b0, 1'b0, 2'd0, 4'd1, 1'b0}};
        tbl[1]  = '{1'b1, 4'b0000, 4'b0000, {1'b1, 1'b0, 2'd2, 4'd0, 1'b0}};
        tbl[2]  = '{1'b1, 4'b0000, 4'b0000, {1'b1, 1'b0, 2'd2, 4'd0, 1'b0}};
        tbl[3]  = '{1'b1, 4'b0000, 4'b0000, {1'b0, 1'b0, 2'd2, 4'd0, 1'b0}};
        tbl[4]  = '{1'b1, 4'b0000, 4'b0000, {1'b0, 1'b0, 2'd2, 4'd0, 1'b1}};
        tbl[5]  = '{1'b1, 4'b0001, 4'b1000, {1'b0, 1'b0, 2'd2, 4'd2, 1'b0}};
        tbl[6]  = '{1'b1, 4'b0000, 4'b0000, {1'b1, 1'b0, 2'd0, 4'd1, 1'b0}};
        tbl[7]  = '{1'b1, 4'b0000, 4'b0000, {1'b1, 1'b0, 2'd0, 4'd1, 1'b0}};
        tbl[8]  = '{1'b1, 4'b0000, 4'b0000, {1'b0, 1'b0, 2'd0, 4'd1, 1'b0}};
        tbl[9]  = '{1'b1, 4'b0000, 4'b0000, {1'b0, 1'b0, 2'd0, 4'd1, 1'b0}};
        tbl[10] = '{1'b1, 4'b0000, 4'b0000, {1'b1, 1'b1, 2'd3, 4'd0, 1'b0}};
        tbl[11] = '{1'b1, 4'b0000, 4'b0000, {1'b1, 1'b1, 2'd3, 4'd0, 1'b0}};
        tbl[12] = '{1'b1, 4'b0000, 4'b0000, {1'b0, 1'b1, 2'd3, 4'd0, 1'b0}};
        tbl[13] = '{1'b1, 4'b0000, 4'b0000, {1'b0, 1'b1, 2'd3, 4'd0, 1'b1}};

        reset = 1'b1;
        busy  = 1'b0;
        drive(1'b0, 4'b0, 4'b0);
        repeat (3) tick();
        check("reset_outputs", {strobe, strb_rel, strb_chan, level, idle, err},
              {1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0});
        check("reset_busy_cnt", busy_cnt, 0);
        check("reset_ovf_cnt", ovf_cnt, 0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].en, tbl[i].abs_v, tbl[i].rel_v);
            tick();
            check($sformatf("vec%0d", i), {strobe, strb_rel, strb_chan, level, idle}, tbl[i].exp);
        end

        // fill with en=0: 10 single events, the last two dropped
        for (int i = 0; i < 10; i++) begin
            if (i[0]) drive(1'b0, 4'b0, 4'(1 << (i % 4)));
            else      drive(1'b0, 4'(1 << (i % 4)), 4'b0);
            if (i < 8) exp_ev[i] = {i[0], 2'(i % 4)};
            tick();
        end
        check("full_level", level, 8);
        check("full_ovf", ovf_cnt, 2);
        check("full_strobe", strobe, 0);

        // pop at full with two pushes: abs takes the freed slot, rel dropped
        drive(1'b1, 4'b0001, 4'b0010);
        exp_ev[8] = {1'b0, 2'd0};
        tick();
        check("full_pop_level", level, 8);
        check("full_pop_ovf", ovf_cnt, 3);
        drive(1'b1, 4'b0, 4'b0);
        prev = 1'b0;
        n = 0;
        for (int c = 0; c < 60 && !idle; c++) begin
            if (strobe && !prev) begin
                if (n < 9) check($sformatf("drain_ev%0d", n), {strb_rel, strb_chan}, exp_ev[n]);
                n++;
            end
            prev = strobe;
            tick();
        end
        check("drain_count", n, 9);
        check("drain_idle", idle, 1);

        check("err_before", err, 0);
        drive(1'b1, 4'b0110, 4'b0);
        tick();
        check("err_set", err, 1);
        check("err_level", level, 0);
        check("err_no_strobe_idle", idle, 1);
        drive(1'b1, 4'b0, 4'b0);
        repeat (3) tick();
        check("err_sticky", err, 1);
        check("err_level_hold", level, 0);

        check("busy_start", busy_cnt, 0);
        busy = 1'b1;
        repeat (100) tick();
        check("busy_100", busy_cnt, 100);
        repeat (200) tick();
        check("busy_sat", busy_cnt, 255);
        busy = 1'b0;
        tick();
        check("busy_hold", busy_cnt, 255);

        drive(1'b0, 4'b0001, 4'b0010);
        tick();
        drive(1'b0, 4'b0100, 4'b0);
        tick();
        check("pre_reset_level", level, 3);
        drive(1'b1, 4'b0, 4'b0);
        n = 0;
        while (!strobe && n < 10) begin
            tick();
            n++;
        end
        check("pre_reset_strobe", strobe, 1);
        tick();
        check("pre_reset_strobe2", {strobe, level}, {1'b1, 4'd2});
        reset = 1'b1;
        tick();
        check("mid_reset_outputs", {strobe, level, idle, err}, {1'b0, 4'd0, 1'b1, 1'b0});
        check("mid_reset_counters", {busy_cnt, ovf_cnt}, 0);
        reset = 1'b0;
        repeat (4) tick();
        check("post_reset_quiet", {strobe, level, idle}, {1'b0, 4'd0, 1'b1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
